addsub_serial: RTL and testbench



---
 rtl/addsub_serial_if.sv | 33 +++
 rtl/addsub_serial.sv | 127 ++++++++++++
 tb/tb_addsub_serial.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: handshake and data bundle for addsub_serial.
//   start    request a transaction (taken only while busy=0)
//   mode     0 = add, 1 = subtract; captured with start
//   val0     operand A; captured with start
//   val1     operand B; captured with start
//   busy     a transaction is in progress
//   done     one-cycle pulse when sum/carry/overflow are updated
//   sum      result (difference when subtracting)
//   carry    unsigned carry-out (add) or borrow-out (subtract)
//   overflow signed two's-complement overflow of the operation
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] val0;
  logic [WIDTH-1:0] val1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, mode, val0, val1,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, mode, val0, val1,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle adder/subtractor processing DIGIT bits per clock,
// least significant digit first, through a registered carry/borrow flop.
// A transaction takes WIDTH/DIGIT RUN cycles; results appear with a one-cycle
// done pulse and then hold until the next completion or reset.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    addsub_serial_if slave: start/mode/val0/val1 in,
//          busy/done/sum/carry/overflow out
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic            clk,
  input logic            rst_n,
  addsub_serial_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             mode_r;
  logic             chain;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;
  logic             done_r;
  logic [DIGIT:0]   slice;
  logic             last;
  logic             ovf_nxt;

  // One digit of add or subtract. The extra top bit is the carry-out for add;
  // for subtract it is set exactly when a-b-bin went negative, i.e. the borrow.
  function automatic logic [DIGIT:0] slice_op(
    input logic             sub,
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             cin
  );
    logic [DIGIT:0] ea;
    logic [DIGIT:0] eb;
    logic [DIGIT:0] ec;
    ea = {1'b0, a};
    eb = {1'b0, b};
    ec = {{DIGIT{1'b0}}, cin};
    return sub ? (ea - eb - ec) : (ea + eb + ec);
  endfunction

  always_comb begin
    state_nxt = state;
    slice     = slice_op(mode_r, a_r[int'(cnt)*DIGIT +: DIGIT],
                         b_r[int'(cnt)*DIGIT +: DIGIT], chain);
    res_nxt   = res_r;
    res_nxt[int'(cnt)*DIGIT +: DIGIT] = slice[DIGIT-1:0];
    last      = (cnt == CNT_W'(N - 1));
    // Subtract overflows when operand signs differ; add when they match.
    // Either way the result sign must then disagree with operand A.
    ovf_nxt   = ((a_r[MSB] ^ b_r[MSB]) == mode_r) && (res_nxt[MSB] != a_r[MSB]);
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      mode_r  <= 1'b0;
      chain   <= 1'b0;
      res_r   <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_r    <= bus.val0;
          b_r    <= bus.val1;
          mode_r <= bus.mode;
          chain  <= 1'b0;
          cnt    <= '0;
        end
      end else begin
        res_r <= res_nxt;
        chain <= slice[DIGIT];
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum_r   <= res_nxt;
          carry_r <= slice[DIGIT];
          ovf_r   <= ovf_nxt;
          done_r  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.carry    = carry_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: drives three addsub_serial instances (DIGIT = 1, 2, 8 at
// WIDTH = 8) from shared stimulus and compares them against an arithmetic
// reference model; directed cases cover busy-start, back-to-back and reset.
module tb_addsub_serial;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] val0;
  logic [7:0] val1;

  int n_chk;
  int n_fail;

  addsub_serial_if #(.WIDTH(8)) bus1 ();
  addsub_serial_if #(.WIDTH(8)) bus2 ();
  addsub_serial_if #(.WIDTH(8)) bus8 ();

  assign bus1.start = start;
  assign bus1.mode  = mode;
  assign bus1.val0  = val0;
  assign bus1.val1  = val1;
  assign bus2.start = start;
  assign bus2.mode  = mode;
  assign bus2.val0  = val0;
  assign bus2.val1  = val1;
  assign bus8.start = start;
  assign bus8.mode  = mode;
  assign bus8.val0  = val0;
  assign bus8.val1  = val1;

  addsub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  addsub_serial #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  addsub_serial #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // index 0: DIGIT=1, index 1: DIGIT=2 (main), index 2: DIGIT=8
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] carry_v;
  logic [2:0] ovf_v;
  logic [7:0] sum_v [3];

  assign busy_v  = {bus8.busy, bus2.busy, bus1.busy};
  assign done_v  = {bus8.done, bus2.done, bus1.done};
  assign carry_v = {bus8.carry, bus2.carry, bus1.carry};
  assign ovf_v   = {bus8.overflow, bus2.overflow, bus1.overflow};
  assign sum_v[0] = bus1.sum;
  assign sum_v[1] = bus2.sum;
  assign sum_v[2] = bus8.sum;

  int         nn [3] = '{8, 4, 1};
  logic [9:0] prev [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry/borrow, sum} from plain integer arithmetic.
  function automatic logic [9:0] ref_op(input logic m, input logic [7:0] a, input logic [7:0] b);
    int   ua, ub, sa, sb, ur, sr;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!m) begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 255);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ub > ua);
    end
    o = (sr > 127) || (sr < -128);
    return {o, c, ur[7:0]};
  endfunction

  // One transaction on all three instances; inputs are scrambled after capture.
  task automatic do_op(input logic m, input logic [7:0] a, input logic [7:0] b);
    logic [9:0] exp;
    int         ndone [3];
    int         nbusy [3];
    int         lat   [3];
    logic [9:0] res   [3];
    logic       moved [3];
    exp = ref_op(m, a, b);
    for (int i = 0; i < 3; i++) begin
      ndone[i] = 0;
      nbusy[i] = 0;
      lat[i]   = -1;
      res[i]   = '0;
      moved[i] = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    val0  = a;
    val1  = b;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i]) nbusy[i]++;
        if (done_v[i]) begin
          ndone[i]++;
          if (lat[i] < 0) begin
            lat[i] = k;
            res[i] = {ovf_v[i], carry_v[i], sum_v[i]};
          end
        end else if (lat[i] < 0 && {ovf_v[i], carry_v[i], sum_v[i]} !== prev[i]) begin
          moved[i] = 1'b1;
        end
      end
      if (k == 0) begin
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        val0  = 8'($urandom);
        val1  = 8'($urandom);
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_done_count", i), 32'(ndone[i]), 32'd1);
      chk($sformatf("d%0d_latency", i), 32'(lat[i]), 32'(nn[i]));
      chk($sformatf("d%0d_busy_cycles", i), 32'(nbusy[i]), 32'(nn[i]));
      chk($sformatf("d%0d_sum", i), 32'(res[i][7:0]), 32'(exp[7:0]));
      chk($sformatf("d%0d_carry", i), 32'(res[i][8]), 32'(exp[8]));
      chk($sformatf("d%0d_overflow", i), 32'(res[i][9]), 32'(exp[9]));
      chk($sformatf("d%0d_hold_during_run", i), 32'(moved[i]), 32'd0);
      prev[i] = exp;
    end
  endtask

  initial begin
    int         nd;
    int         kd;
    int         phase;
    logic [9:0] e;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    val0   = '0;
    val1   = '0;
    for (int i = 0; i < 3; i++) prev[i] = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_v), 32'd0);
    chk("reset_done", 32'(done_v), 32'd0);
    chk("reset_sum", 32'(sum_v[1]), 32'd0);
    chk("reset_flags", 32'({carry_v, ovf_v}), 32'd0);
    rst_n = 1'b1;

    // Directed arithmetic cases, then random ones.
    do_op(1'b0, 8'h3C, 8'h55);
    do_op(1'b1, 8'h10, 8'h20);
    do_op(1'b1, 8'h80, 8'h01);
    do_op(1'b0, 8'hFF, 8'h01);
    do_op(1'b1, 8'h00, 8'h00);
    do_op(1'b0, 8'h7F, 8'h7F);
    for (int r = 0; r < 24; r++)
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

    // start during RUN is ignored, mid-run input changes have no effect.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; val0 = 8'h3C; val1 = 8'h55;
    nd = 0; kd = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_v[1]) begin
        nd++;
        if (kd < 0) begin
          kd = k;
          chk("t4_sum", 32'(sum_v[1]), 32'h91);
          chk("t4_flags", 32'({ovf_v[1], carry_v[1]}), 32'b10);
        end
      end
      if (k == 0) start = 1'b0;
      if (k == 1) begin
        start = 1'b1; mode = 1'b1; val0 = 8'hAA; val1 = 8'h11;
      end
      if (k == 2) begin
        start = 1'b0; val0 = 8'($urandom); val1 = 8'($urandom);
      end
    end
    chk("t4_latency", 32'(kd), 32'd4);
    chk("t4_done_count", 32'(nd), 32'd1);

    // Back-to-back: start held in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; val0 = 8'h05; val1 = 8'h03;
    phase = 0; kd = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (phase == 0 && done_v[1]) begin
        chk("t5_first_sum", 32'(sum_v[1]), 32'h08);
        start = 1'b1; mode = 1'b1; val0 = 8'h01; val1 = 8'h02;
        kd = k;
        phase = 1;
      end else if (phase == 1) begin
        chk("t5_busy_next", 32'(busy_v[1]), 32'd1);
        start = 1'b0;
        phase = 2;
      end else if (phase == 2 && done_v[1]) begin
        e = ref_op(1'b1, 8'h01, 8'h02);
        chk("t5_latency", 32'(k - kd), 32'd5);
        chk("t5_sum", 32'(sum_v[1]), 32'(e[7:0]));
        chk("t5_carry", 32'(carry_v[1]), 32'(e[8]));
        chk("t5_overflow", 32'(ovf_v[1]), 32'(e[9]));
        phase = 3;
      end
    end
    chk("t5_complete", 32'(phase), 32'd3);

    // Reset in busy cycle 3 abandons the transaction and clears outputs.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; val0 = 8'h3C; val1 = 8'h55;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_before", 32'(busy_v[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy_v[1]), 32'd0);
    chk("t6_done", 32'(done_v[1]), 32'd0);
    chk("t6_sum", 32'(sum_v[1]), 32'd0);
    chk("t6_flags", 32'({carry_v[1], ovf_v[1]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_v[1] || busy_v[1]) nd++;
    end
    chk("t6_no_activity", 32'(nd), 32'd0);
    for (int i = 0; i < 3; i++) prev[i] = '0;
    do_op(1'b0, 8'h05, 8'h03);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
